nibble_sorter: RTL and testbench



---
 rtl/nibble_sorter_if.sv | 23 ++
 rtl/nibble_sorter.sv | 141 ++++++++++++++
 tb/tb_nibble_sorter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_sorter_if.sv
// Handshake/data bundle between a sort requester and nibble_sorter.
// DEPTH must match the DEPTH of the nibble_sorter instance it connects to.
interface nibble_sorter_if #(
  parameter int DEPTH = 4
);
  logic                 start;
  logic                 descend;
  logic [4*DEPTH-1:0]   din;
  logic                 busy;
  logic                 done;
  logic [4*DEPTH-1:0]   dout;
  logic [5:0]           swap_cnt;

  modport master (
    output start, descend, din,
    input  busy, done, dout, swap_cnt
  );

  modport slave (
    input  start, descend, din,
    output busy, done, dout, swap_cnt
  );
endinterface

// File: rtl/nibble_sorter.sv
// Bubble sorter for DEPTH nibbles, one compare/conditional swap per clock through a shared
// FourBit_Comparator. Define NIBBLE_SORTER_EARLY_EXIT_EN to stop after the first swap-free pass.
module FourBit_Comparator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       eq,
  output logic       gt,
  output logic       lt
);
  assign eq = (A == B);
  assign gt = (A > B);
  assign lt = (A < B);
endmodule

module nibble_sorter #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  nibble_sorter_if.slave sif
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [3:0]         r    [DEPTH];
  logic [3:0]         r_sw [DEPTH];
  logic [4*DEPTH-1:0] r_sw_flat;
  logic [IW-1:0]      i, pass, i_nxt, last_i;
  logic               desc_q;
  logic [5:0]         cnt;
  logic [3:0]         cmp_a, cmp_b;
  logic               cmp_eq, cmp_gt, cmp_lt;
  logic               swap, stop_early;

  assign i_nxt  = i + IW'(1);
  assign last_i = IW'(DEPTH - 2) - pass;

  // The only comparator: both operands are muxed by the scan index.
  assign cmp_a = r[i];
  assign cmp_b = r[i_nxt];

  FourBit_Comparator u_cmp (
    .A  (cmp_a),
    .B  (cmp_b),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign swap = (state == SCAN) && !cmp_eq && (desc_q ? cmp_lt : cmp_gt);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    r_sw      = r;
    r_sw_flat = '0;
    if (swap) begin
      r_sw[i]     = cmp_b;
      r_sw[i_nxt] = cmp_a;
    end
    for (int k = 0; k < DEPTH; k++) r_sw_flat[4*k +: 4] = r_sw[k];
  end

`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
  logic pass_swap;
  assign stop_early = !(pass_swap || swap);
`else
  assign stop_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      // NOTE: the working array is a handful of flops, so it is reset like every other register.
      for (int k = 0; k < DEPTH; k++) r[k] <= '0;
      i            <= '0;
      pass         <= '0;
      desc_q       <= 1'b0;
      cnt          <= '0;
      sif.busy     <= 1'b0;
      sif.done     <= 1'b0;
      sif.dout     <= '0;
      sif.swap_cnt <= '0;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
      pass_swap    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sif.done <= 1'b0;
          if (sif.start) begin
            for (int k = 0; k < DEPTH; k++) r[k] <= sif.din[4*k +: 4];
            desc_q   <= sif.descend;
            i        <= '0;
            pass     <= '0;
            cnt      <= '0;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
            pass_swap <= 1'b0;
`endif
            sif.busy <= 1'b1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          r   <= r_sw;
          cnt <= cnt + 6'(swap);
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
          pass_swap <= pass_swap | swap;
`endif
          if (i == last_i) begin
            if (pass == IW'(DEPTH - 2) || stop_early) begin
              sif.done     <= 1'b1;
              sif.dout     <= r_sw_flat;
              sif.swap_cnt <= cnt + 6'(swap);
              state        <= DONE;
            end else begin
              pass <= pass + IW'(1);
              i    <= '0;
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
              pass_swap <= 1'b0;
`endif
            end
          end else begin
            i <= i_nxt;
          end
        end

        DONE: begin
          sif.done <= 1'b0;
          sif.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_sorter.sv
// Self-checking bench for nibble_sorter: directed cases plus random sorts against a counting model.
// Build with or without NIBBLE_SORTER_EARLY_EXIT_EN; the model follows the same macro.
module tb_nibble_sorter;
  localparam int DEPTH = 4;
  localparam int W     = 4 * DEPTH;

  typedef logic [3:0] arr_t [DEPTH];

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_sorter_if #(.DEPTH(DEPTH)) sif ();

  nibble_sorter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input arr_t a);
    logic [W-1:0] v;
    v = '0;
    for (int e = 0; e < DEPTH; e++) v[4*e +: 4] = a[e];
    return v;
  endfunction

  // Sorted vector by value buckets, swaps as the inversion count, latency from the largest
  // per-element inversion count (number of passes that still move something).
  function automatic void model(input arr_t a, input bit desc, output logic [W-1:0] srt,
                                output int swaps, output int k);
    int pos, v, left, p_max, passes;
    pos   = 0;
    srt   = '0;
    swaps = 0;
    p_max = 0;
    for (int t = 0; t < 16; t++) begin
      v = desc ? 15 - t : t;
      for (int e = 0; e < DEPTH; e++) begin
        if (int'(a[e]) == v) begin
          srt[4*pos +: 4] = a[e];
          pos++;
        end
      end
    end
    for (int c = 1; c < DEPTH; c++) begin
      left = 0;
      for (int j = 0; j < c; j++) if (desc ? (a[j] < a[c]) : (a[j] > a[c])) left++;
      swaps += left;
      if (left > p_max) p_max = left;
    end
`ifdef NIBBLE_SORTER_EARLY_EXIT_EN
    passes = (p_max + 1 < DEPTH - 1) ? p_max + 1 : DEPTH - 1;
`else
    passes = DEPTH - 1;
`endif
    k = 0;
    for (int p = 0; p < passes; p++) k += DEPTH - 1 - p;
  endfunction

  // Called at the negedge after edge n0 (edge 0 sampled start); returns at the negedge in DONE.
  task automatic wait_done(input string tag, input int n0, input logic [W-1:0] exp_dout,
                           input int exp_cnt, input int exp_k);
    int n;
    bit got;
    n   = n0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sif.done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_k));
    check({tag, "_dout"}, 32'(sif.dout), 32'(exp_dout));
    check({tag, "_swap_cnt"}, 32'(sif.swap_cnt), 32'(exp_cnt));
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] exp_dout);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
    check({tag, "_busy_low"}, 32'(sif.busy), 32'd0);
    check({tag, "_dout_hold"}, 32'(sif.dout), 32'(exp_dout));
  endtask

  task automatic do_sort(input string tag, input arr_t a, input bit desc);
    logic [W-1:0] srt;
    int swaps, k;
    model(a, desc, srt, swaps, k);
    @(negedge clk);
    sif.din     = pack(a);
    sif.descend = desc;
    sif.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    check({tag, "_busy_rise"}, 32'(sif.busy), 32'd1);
    wait_done(tag, 0, srt, swaps, k);
    after_done(tag, srt);
  endtask

  initial begin
    arr_t a, b, c;
    logic [W-1:0] srt;
    int swaps, k;
    checks = 0;
    errors = 0;

    // Reset held with start asserted.
    rst_n       = 1'b0;
    sif.start   = 1'b1;
    sif.descend = 1'b0;
    sif.din     = 16'h4528;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_dout", 32'(sif.dout), 32'd0);
    check("rst_swap_cnt", 32'(sif.swap_cnt), 32'd0);
    sif.start = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 32'(sif.busy), 32'd0);
    check("idle_done", 32'(sif.done), 32'd0);

    // Directed cases.
    a = '{4'h8, 4'h2, 4'h5, 4'h4};
    do_sort("asc", a, 1'b0);
    check("asc_const", 32'(sif.dout), 32'h8542);
    check("asc_cnt_const", 32'(sif.swap_cnt), 32'd4);

    a = '{4'h1, 4'h3, 4'h5, 4'h7};
    do_sort("sorted", a, 1'b0);
    check("sorted_const", 32'(sif.dout), 32'h7531);

    a = '{4'h5, 4'h5, 4'h0, 4'hF};
    do_sort("desc_ties", a, 1'b1);
    check("desc_ties_const", 32'(sif.dout), 32'h055F);
    check("desc_ties_cnt_const", 32'(sif.swap_cnt), 32'd3);

    // Start pulsed during SCAN is ignored; start held through DONE is taken in the next IDLE.
    a = '{4'h8, 4'h2, 4'h5, 4'h4};
    b = '{4'hF, 4'hE, 4'hD, 4'hC};
    model(a, 1'b0, srt, swaps, k);
    @(negedge clk);
    sif.din     = pack(a);
    sif.descend = 1'b0;
    sif.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    sif.din   = pack(b);
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    check("busy_start_busy", 32'(sif.busy), 32'd1);
    wait_done("busy_start", 3, srt, swaps, k);
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("held_start_idle", 32'(sif.busy), 32'd0);
    model(b, 1'b0, srt, swaps, k);
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    check("held_start_busy", 32'(sif.busy), 32'd1);
    wait_done("held_start", 0, srt, swaps, k);
    check("held_start_const", 32'(sif.dout), 32'hFEDC);
    after_done("held_start", srt);

    // Reset dropped mid-sort.
    a = '{4'h8, 4'h2, 4'h5, 4'h4};
    @(negedge clk);
    sif.din   = pack(a);
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(sif.busy), 32'd0);
    check("midrst_done", 32'(sif.done), 32'd0);
    check("midrst_dout", 32'(sif.dout), 32'd0);
    check("midrst_swap_cnt", 32'(sif.swap_cnt), 32'd0);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_done", 32'(sif.done), 32'd0);
    end
    rst_n = 1'b1;
    do_sort("post_rst", a, 1'b0);
    check("post_rst_const", 32'(sif.dout), 32'h8542);

    // Random sorts; half of them drawn from a narrow range to force ties.
    for (int t = 0; t < 30; t++) begin
      for (int e = 0; e < DEPTH; e++)
        c[e] = (t % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      do_sort($sformatf("rand%0d", t), c, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
